// File: rtl/fpq_pkg.sv
// Shared constants and the classification type for the FP32 quantizer.
// Imported by the pipeline top and by the round/clamp stage.
package fpq_pkg;

    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;
    localparam int FP_W      = 32;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_SAT  = 2'd2,
        CLS_EXC  = 2'd3
    } cls_t;

endpackage

// File: rtl/fpq_round_sat.sv
// Round-half-away-from-zero on the magnitude, apply sign, clamp to OUT_W.
// The magnitude input carries one fraction bit (the half bit) as its LSB.
module fpq_round_sat
    import fpq_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  cls_t             cls,
    input  logic             sign,
    input  logic [OUT_W:0]   mag,
    output logic [OUT_W-1:0] data,
    output logic             sat,
    output logic             exc
);

    localparam logic [OUT_W:0]   LIM_P = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   LIM_N = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_D = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_D = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W:0] rounded;

    always_comb begin
        data    = '0;
        sat     = 1'b0;
        exc     = 1'b0;
        rounded = {1'b0, mag[OUT_W:1]} + (OUT_W+1)'(mag[0]);
        unique case (cls)
            CLS_EXC: exc = 1'b1;
            CLS_SAT: begin
                sat  = 1'b1;
                data = sign ? MIN_D : MAX_D;
            end
            CLS_ZERO: data = '0;
            CLS_NORM: begin
                if (!sign) begin
                    if (rounded > LIM_P) begin
                        sat  = 1'b1;
                        data = MAX_D;
                    end else begin
                        data = rounded[OUT_W-1:0];
                    end
                // -2^(OUT_W-1) is representable, so only beyond it clamps
                end else if (rounded > LIM_N) begin
                    sat  = 1'b1;
                    data = MIN_D;
                end else begin
                    data = -rounded[OUT_W-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_quant_convert.sv
// FP32 product to signed OUT_W integer quantizer, two-stage valid/ready pipe.
// S1 classifies and aligns; S2 registers the rounded/clamped result.
module fp_quant_convert
    import fpq_pkg::*;
#(
    parameter int OUT_W    = OUT_W_DEF,
    parameter int SATCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FP_W-1:0]     in_data,
    input  logic                in_exception,
    input  logic                in_overflow,
    input  logic                in_underflow,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat,
    output logic                out_exc,
    output logic [SATCNT_W-1:0] sat_count
);

    logic [7:0]     exp_f;
    logic [22:0]    man_f;
    logic [4:0]     sh;
    logic [54:0]    sig_w;
    cls_t           cls_c;
    logic [OUT_W:0] mag_c;

    logic           v1;
    cls_t           cls1;
    logic           sgn1;
    logic [OUT_W:0] mag1;
    logic           v2;

    logic [OUT_W-1:0] rs_data;
    logic             rs_sat;
    logic             rs_exc;
    logic             stall;

    assign exp_f = in_data[30:23];
    assign man_f = in_data[22:0];

    // Reset masks out_valid so no output transfer happens in the reset cycle
    assign out_valid = v2 & ~rst;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    always_comb begin
        cls_c = CLS_NORM;
        if (in_exception || (exp_f == 8'(EXP_MAX) && man_f != '0))
            cls_c = CLS_EXC;
        else if (in_overflow || exp_f == 8'(EXP_MAX))
            cls_c = CLS_SAT;
        else if (in_underflow || exp_f == 8'd0)
            cls_c = CLS_ZERO;
        else if (exp_f < 8'(EXP_BIAS - 1))
            cls_c = CLS_ZERO;
        else if (exp_f >= 8'(EXP_BIAS + OUT_W))
            cls_c = CLS_SAT;
    end

    // Magnitude with one fraction bit: floor(1.mant * 2^(exp-127) * 2)
    assign sh    = 5'(exp_f - 8'(EXP_BIAS - 1));
    assign sig_w = {31'b0, 1'b1, man_f};
    assign mag_c = (OUT_W+1)'((sig_w << sh) >> 23);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            cls1 <= CLS_ZERO;
            sgn1 <= 1'b0;
            mag1 <= '0;
        end else if (!stall) begin
            v1   <= in_valid;
            cls1 <= cls_c;
            sgn1 <= in_data[31];
            mag1 <= mag_c;
        end
    end

    fpq_round_sat #(
        .OUT_W(OUT_W)
    ) u_round_sat (
        .cls (cls1),
        .sign(sgn1),
        .mag (mag1),
        .data(rs_data),
        .sat (rs_sat),
        .exc (rs_exc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_exc  <= 1'b0;
        end else if (!stall) begin
            v2       <= v1;
            out_data <= rs_data;
            out_sat  <= rs_sat;
            out_exc  <= rs_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != '1)
            sat_count <= sat_count + 1'b1;
    end

endmodule

// File: tb/tb_fp_quant_convert.sv
// Directed-vector bench for fp_quant_convert at default parameters.
// Covers rounding, clamping, class priority, stall and mid-stream reset.
module tb_fp_quant_convert;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_exception;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_exc;
    logic [15:0] sat_count;

    int n_vec   = 0;
    int n_err   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    fp_quant_convert dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_exception(in_exception),
        .in_overflow (in_overflow),
        .in_underflow(in_underflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_exc     (out_exc),
        .sat_count   (sat_count)
    );

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic apply(input string tag, input logic [31:0] d,
                         input logic e, input logic o, input logic u,
                         input int want, input int wsat, input int wexc);
        in_valid     = 1'b1;
        in_data      = d;
        in_exception = e;
        in_overflow  = o;
        in_underflow = u;
        #1;
        check({tag, ".in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".v_early"}, int'(out_valid), 0);
        @(posedge clk); #1;
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".data"}, $signed(out_data), want);
        check({tag, ".sat"}, int'(out_sat), wsat);
        check({tag, ".exc"}, int'(out_exc), wexc);
        exp_cnt += wsat;
        @(posedge clk); #1;
        check({tag, ".satcnt"}, int'(sat_count), exp_cnt);
    endtask

    logic [31:0] sw [4];
    int          sx [4];
    int          rx [$];
    int          sent, got_n, stalls;
    logic        acc, take;
    logic [15:0] held;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_exception = 1'b0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", int'(out_valid), 0);
        check("reset.data", $signed(out_data), 0);
        check("reset.satcnt", int'(sat_count), 0);
        check("reset.in_ready", int'(in_ready), 1);
        rst = 1'b0;
        #1;
        check("post_reset.in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        apply("p5_99",  32'h40BFFFE0, 0, 0, 0, 6, 0, 0);
        apply("p14_06", 32'h4160FFDA, 0, 0, 0, 14, 0, 0);
        apply("n5_99",  32'hC0BFFFE0, 0, 0, 0, -6, 0, 0);
        apply("p0_0098",32'h3C200013, 0, 0, 0, 0, 0, 0);
        apply("p2_5",   32'h40200000, 0, 0, 0, 3, 0, 0);
        apply("n2_5",   32'hC0200000, 0, 0, 0, -3, 0, 0);
        apply("p0_5",   32'h3F000000, 0, 0, 0, 1, 0, 0);
        apply("p40000", 32'h471C4000, 0, 0, 0, 32767, 1, 0);
        apply("n32768", 32'hC7000000, 0, 0, 0, -32768, 0, 0);
        apply("exc",    32'h40200000, 1, 1, 0, 0, 0, 1);
        apply("ovf_neg",32'hC0000000, 0, 1, 0, -32768, 1, 0);
        apply("nan",    32'h7FC00000, 0, 0, 0, 0, 0, 1);
        apply("pinf",   32'h7F800000, 0, 0, 0, 32767, 1, 0);
        apply("nzero",  32'h80000000, 0, 0, 0, 0, 0, 0);
        apply("n0_4",   32'hBECCCCCD, 0, 0, 0, 0, 0, 0);
        apply("n0_5",   32'hBF000000, 0, 0, 0, -1, 0, 0);
        apply("unf",    32'h40A00000, 0, 0, 1, 0, 0, 0);
        apply("p65536", 32'h47800000, 0, 0, 0, 32767, 1, 0);
        apply("p32767_5",32'h46FFFF00, 0, 0, 0, 32767, 1, 0);

        sw = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hC0800000};
        sx = '{1, 2, 3, -4};
        sent   = 0;
        got_n  = 0;
        stalls = 0;
        held   = '0;
        for (int c = 0; c < 30 && got_n < 4; c++) begin
            in_valid  = (sent < 4);
            in_data   = (sent < 4) ? sw[sent] : 32'h0;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check("stall.in_ready", int'(in_ready), 0);
                if (stalls > 1)
                    check("stall.hold", $signed(out_data), $signed(held));
                held = out_data;
            end
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) rx.push_back(int'($signed(out_data)));
            @(posedge clk); #1;
            if (acc) sent++;
            if (take) got_n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream.stalls", stalls, 3);
        check("stream.count", rx.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stream.w%0d", i),
                  (i < rx.size()) ? rx[i] : 99999, sx[i]);

        in_valid = 1'b1;
        in_data  = 32'h40E00000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid.pre_valid", int'(out_valid), 1);
        check("rst_mid.pre_data", $signed(out_data), 7);
        rst = 1'b1;
        #1;
        check("rst_mid.valid_in_rst", int'(out_valid), 0);
        check("rst_mid.ready_in_rst", int'(in_ready), 1);
        @(posedge clk); #1;
        check("rst_mid.valid_next", int'(out_valid), 0);
        check("rst_mid.data_clr", $signed(out_data), 0);
        check("rst_mid.satcnt_clr", int'(sat_count), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_mid.ready_after", int'(in_ready), 1);
        @(posedge clk); #1;
        check("rst_mid.flushed1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("rst_mid.flushed2", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
